// File: rtl/compress_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : compress_stream_ctrl
// Purpose  : Ingress/egress AXI-Stream sequencer for the eight-lane compress
//            pipeline. It builds the per-beat flag word and appends a flush
//            beat after each compressed packet. Define COMPRESS_CTRL_STATS_EN
//            to add the stat_pkts and stat_flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module compress_stream_ctrl #(
    parameter int LANE_WIDTH  = 32,
    parameter int LANES       = 8,
    parameter int TAG_WIDTH   = 2,
    parameter int LEN_WIDTH   = 8,
    parameter int TKEEP_WIDTH = 32,
    parameter int HDR_BEATS   = 1,
    parameter int PIPE_DEPTH  = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_compress_en,
    input  logic [LANE_WIDTH*LANES-1:0]     s_tdata,
    input  logic [TKEEP_WIDTH-1:0]          s_tkeep,
    input  logic                            s_tlast,
    input  logic                            s_tvalid,
    output logic                            s_tready,
    output logic                            pipe_wrtEn,
    output logic [LANE_WIDTH*LANES-1:0]     pipe_dataIn,
    output logic [TKEEP_WIDTH+3:0]          pipe_flags_in,
    input  logic [LANE_WIDTH*LANES-1:0]     pipe_dataOut,
    input  logic [TAG_WIDTH*LANES-1:0]      pipe_tagOut,
    input  logic [LEN_WIDTH-1:0]            pipe_lenOut,
    input  logic [TKEEP_WIDTH+3:0]          pipe_flags_out,
    output logic [LANE_WIDTH*LANES-1:0]     m_tdata,
    output logic [TAG_WIDTH*LANES-1:0]      m_ttag,
    output logic [LEN_WIDTH-1:0]            m_tlen,
    output logic [TKEEP_WIDTH-1:0]          m_tkeep,
    output logic                            m_tlast,
    output logic                            m_tvalid,
    input  logic                            m_tready,
`ifdef COMPRESS_CTRL_STATS_EN
    output logic [31:0]                     stat_pkts,
    output logic [31:0]                     stat_flush,
`endif
    output logic                            busy
);

    localparam int c_DATA_W = LANE_WIDTH * LANES;
    localparam int c_INF_W  = $clog2(PIPE_DEPTH + 2);
    localparam int c_HDR_W  = $clog2(HDR_BEATS + 1);
    localparam logic [c_INF_W-1:0] c_INF_MAX  = c_INF_W'(PIPE_DEPTH + 1);
    localparam logic [c_HDR_W-1:0] c_HDR_LAST = c_HDR_W'(HDR_BEATS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t               r_state_q,    w_state_d;
    logic [c_HDR_W-1:0]   r_hdr_cnt_q,  w_hdr_cnt_d;
    logic                 r_pkt_comp_q, w_pkt_comp_d;
    logic [c_INF_W-1:0]   r_inflight_q, w_inflight_d;

    logic                 w_wrt_en;
    logic                 w_accept;
    logic                 w_egress_hs;
    logic                 w_flush_inj;
    logic [c_DATA_W-1:0]  w_inj_data;
    logic [TKEEP_WIDTH-1:0] w_inj_keep;
    logic                 w_inj_valid;
    logic                 w_inj_last;
    logic                 w_inj_comp;
    logic                 w_inj_hdr;
    logic [1:0]           w_unused_flags;

    // The whole pipeline freezes while its output beat waits on the packer.
    assign w_wrt_en    = !(pipe_flags_out[3] && !m_tready);
    assign w_accept    = s_tvalid && s_tready;
    assign w_egress_hs = m_tvalid && m_tready;

    assign pipe_wrtEn    = w_wrt_en;
    assign s_tready      = w_wrt_en && (r_state_q != ST_FLUSH);
    assign pipe_dataIn   = w_inj_data;
    assign pipe_flags_in = {w_inj_keep, w_inj_valid, w_inj_last, w_inj_comp, w_inj_hdr};

    assign m_tdata  = pipe_dataOut;
    assign m_ttag   = pipe_tagOut;
    assign m_tlen   = pipe_lenOut;
    assign m_tkeep  = pipe_flags_out[TKEEP_WIDTH+3:4];
    assign m_tlast  = pipe_flags_out[2];
    assign m_tvalid = pipe_flags_out[3];
    assign w_unused_flags = pipe_flags_out[1:0];

    assign busy = (r_state_q != ST_IDLE) || (r_inflight_q != '0);

    always_comb begin
        w_state_d    = r_state_q;
        w_hdr_cnt_d  = r_hdr_cnt_q;
        w_pkt_comp_d = r_pkt_comp_q;
        w_inj_data   = '0;
        w_inj_keep   = '0;
        w_inj_valid  = 1'b0;
        w_inj_last   = 1'b0;
        w_inj_comp   = 1'b0;
        w_inj_hdr    = 1'b0;
        w_flush_inj  = 1'b0;

        if (r_state_q == ST_FLUSH) begin
            // Empty beat that pushes the carried half-lane residue out.
            if (w_wrt_en) begin
                w_inj_valid = 1'b1;
                w_inj_last  = 1'b1;
                w_inj_comp  = 1'b1;
                w_flush_inj = 1'b1;
                w_state_d   = ST_IDLE;
            end
        end else if (w_accept) begin
            w_inj_data  = s_tdata;
            w_inj_keep  = s_tkeep;
            w_inj_valid = 1'b1;
            case (r_state_q)
                ST_IDLE: begin
                    w_pkt_comp_d = cfg_compress_en;
                    w_hdr_cnt_d  = c_HDR_W'(1);
                    w_inj_hdr    = 1'b1;
                    w_inj_last   = s_tlast;
                    if (s_tlast)
                        w_state_d = ST_IDLE;
                    else if (HDR_BEATS > 1)
                        w_state_d = ST_HDR;
                    else
                        w_state_d = ST_PAYLOAD;
                end
                ST_HDR: begin
                    w_hdr_cnt_d = r_hdr_cnt_q + 1'b1;
                    w_inj_hdr   = 1'b1;
                    w_inj_last  = s_tlast;
                    if (s_tlast)
                        w_state_d = ST_IDLE;
                    else if (w_hdr_cnt_d >= c_HDR_LAST)
                        w_state_d = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    w_inj_comp = r_pkt_comp_q;
                    if (s_tlast) begin
                        // Compressed packets end on the flush beat instead.
                        w_inj_last = !r_pkt_comp_q;
                        w_state_d  = r_pkt_comp_q ? ST_FLUSH : ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_inflight_d = r_inflight_q;
        case ({w_wrt_en && w_inj_valid, w_egress_hs})
            2'b10:   if (r_inflight_q != c_INF_MAX) w_inflight_d = r_inflight_q + 1'b1;
            2'b01:   if (r_inflight_q != '0)        w_inflight_d = r_inflight_q - 1'b1;
            default: w_inflight_d = r_inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= ST_IDLE;
            r_hdr_cnt_q  <= '0;
            r_pkt_comp_q <= 1'b0;
            r_inflight_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_hdr_cnt_q  <= w_hdr_cnt_d;
            r_pkt_comp_q <= w_pkt_comp_d;
            r_inflight_q <= w_inflight_d;
        end
    end

`ifdef COMPRESS_CTRL_STATS_EN
    logic [31:0] r_stat_pkts_q,  w_stat_pkts_d;
    logic [31:0] r_stat_flush_q, w_stat_flush_d;

    always_comb begin
        w_stat_pkts_d  = r_stat_pkts_q + {31'd0, w_egress_hs && m_tlast};
        w_stat_flush_d = r_stat_flush_q + {31'd0, w_flush_inj};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_pkts_q  <= '0;
            r_stat_flush_q <= '0;
        end else begin
            r_stat_pkts_q  <= w_stat_pkts_d;
            r_stat_flush_q <= w_stat_flush_d;
        end
    end

    assign stat_pkts  = r_stat_pkts_q;
    assign stat_flush = r_stat_flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_compress_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_compress_stream_ctrl
// Purpose  : Directed self-checking bench for compress_stream_ctrl with a
//            five-stage stand-in pipeline that honours pipe_wrtEn and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_compress_stream_ctrl;

    localparam int c_DEPTH = 5;

    logic         clk;
    logic         reset;
    logic         cfg_compress_en;
    logic [255:0] s_tdata;
    logic [31:0]  s_tkeep;
    logic         s_tlast;
    logic         s_tvalid;
    logic         s_tready;
    logic         pipe_wrtEn;
    logic [255:0] pipe_dataIn;
    logic [35:0]  pipe_flags_in;
    logic [255:0] pipe_dataOut;
    logic [15:0]  pipe_tagOut;
    logic [7:0]   pipe_lenOut;
    logic [35:0]  pipe_flags_out;
    logic [255:0] m_tdata;
    logic [15:0]  m_ttag;
    logic [7:0]   m_tlen;
    logic [31:0]  m_tkeep;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready;
    logic         busy;

    compress_stream_ctrl u_dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_compress_en (cfg_compress_en),
        .s_tdata         (s_tdata),
        .s_tkeep         (s_tkeep),
        .s_tlast         (s_tlast),
        .s_tvalid        (s_tvalid),
        .s_tready        (s_tready),
        .pipe_wrtEn      (pipe_wrtEn),
        .pipe_dataIn     (pipe_dataIn),
        .pipe_flags_in   (pipe_flags_in),
        .pipe_dataOut    (pipe_dataOut),
        .pipe_tagOut     (pipe_tagOut),
        .pipe_lenOut     (pipe_lenOut),
        .pipe_flags_out  (pipe_flags_out),
        .m_tdata         (m_tdata),
        .m_ttag          (m_ttag),
        .m_tlen          (m_tlen),
        .m_tkeep         (m_tkeep),
        .m_tlast         (m_tlast),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in pipeline: plain enabled shift register, tag/len derived from data.
    logic [255:0] r_pd [c_DEPTH];
    logic [35:0]  r_pf [c_DEPTH];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_pd[i] <= '0;
                r_pf[i] <= '0;
            end
        end else if (pipe_wrtEn) begin
            r_pd[0] <= pipe_dataIn;
            r_pf[0] <= pipe_flags_in;
            for (int i = 1; i < c_DEPTH; i++) begin
                r_pd[i] <= r_pd[i-1];
                r_pf[i] <= r_pf[i-1];
            end
        end
    end
    assign pipe_dataOut   = r_pd[c_DEPTH-1];
    assign pipe_flags_out = r_pf[c_DEPTH-1];
    assign pipe_tagOut    = r_pd[c_DEPTH-1][15:0];
    assign pipe_lenOut    = r_pd[c_DEPTH-1][7:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [255:0] q_data [$];
    logic [31:0]  q_keep [$];
    logic         q_last [$];
    int           q_cyc  [$];
    always @(negedge clk) begin
        if (!reset && m_tvalid && m_tready) begin
            q_data.push_back(m_tdata);
            q_keep.push_back(m_tkeep);
            q_last.push_back(m_tlast);
            q_cyc.push_back(cyc + 1);
        end
    end

    int   n_checks = 0;
    int   n_errors = 0;
    int   last_acc = 0;
    int   waits    = 0;
    logic busy_prev;
    logic busy_done;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk(input logic [31:0] v);
        return {8{v}};
    endfunction

    task automatic clear_q();
        q_data.delete(); q_keep.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l,
                             input logic chk, input logic [35:0] ef);
        int n = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
        #1;
        while (!s_tready && n < 50) begin
            step();
            n++;
        end
        waits += n;
        if (n >= 50) check("accept_timeout", s_tready, 1);
        if (chk) begin
            check("flags_in", pipe_flags_in, ef);
            check("data_in", pipe_dataIn, d);
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
    endtask

    task automatic drain(input int n, input string tag);
        int k = 0;
        busy_prev = busy;
        while (q_data.size() < n && k < 200) begin
            busy_prev = busy;
            step();
            k++;
        end
        if (k >= 200) check({tag, "_timeout"}, q_data.size(), n);
        busy_done = busy;
        repeat (10) step();
        check({tag, "_count"}, q_data.size(), n);
    endtask

    localparam logic [31:0] c_KF = 32'hFFFF_FFFF;
    localparam logic [31:0] c_KL = 32'h0000_FFFF;

    initial begin
        int c0;
        reset = 1'b1; cfg_compress_en = 1'b0; s_tdata = '0; s_tkeep = '0;
        s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_wrten", pipe_wrtEn, 1);
        check("rst_s_tready", s_tready, 1);
        check("rst_flags_in", pipe_flags_in, 0);
        check("rst_data_in", pipe_dataIn, 0);

        // Compressed 4-beat packet: header, 3 payload, then a flush beat.
        clear_q(); cfg_compress_en = 1'b1;
        send_beat(mk(32'hA000_0001), c_KF, 1'b0, 1'b1, {c_KF, 4'b1001});
        c0 = last_acc;
        cfg_compress_en = 1'b0;
        send_beat(mk(32'hA000_0002), c_KF, 1'b0, 1'b1, {c_KF, 4'b1010});
        send_beat(mk(32'hA000_0003), c_KF, 1'b0, 1'b1, {c_KF, 4'b1010});
        send_beat(mk(32'hA000_0004), c_KL, 1'b1, 1'b1, {c_KL, 4'b1010});
        s_tvalid = 1'b0;
        #1;
        check("flush_s_tready", s_tready, 0);
        check("flush_flags", pipe_flags_in, 36'hE);
        check("flush_data", pipe_dataIn, 0);
        drain(5, "comp4");
        check("comp4_busy_before", busy_prev, 1);
        check("comp4_busy_after", busy_done, 0);
        for (int i = 0; i < 5 && i < q_data.size(); i++) begin
            check("comp4_lat", q_cyc[i] - c0, 5 + i);
            check("comp4_last", q_last[i], i == 4);
            check("comp4_data", q_data[i], i == 4 ? 256'h0 : mk(32'hA000_0001 + i));
        end
        if (q_keep.size() == 5) check("comp4_flush_keep", q_keep[4], 0);

        // Same packet uncompressed: no flush beat.
        clear_q(); cfg_compress_en = 1'b0;
        send_beat(mk(32'hB000_0001), c_KF, 1'b0, 1'b1, {c_KF, 4'b1001});
        c0 = last_acc;
        send_beat(mk(32'hB000_0002), c_KF, 1'b0, 1'b1, {c_KF, 4'b1000});
        send_beat(mk(32'hB000_0003), c_KF, 1'b0, 1'b1, {c_KF, 4'b1000});
        send_beat(mk(32'hB000_0004), c_KL, 1'b1, 1'b1, {c_KL, 4'b1100});
        s_tvalid = 1'b0;
        drain(4, "raw4");
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            check("raw4_lat", q_cyc[i] - c0, 5 + i);
            check("raw4_last", q_last[i], i == 3);
        end
        if (q_keep.size() == 4) check("raw4_keep", q_keep[3], c_KL);

        // Single-beat packet, compression requested: tlast in header, no flush.
        clear_q(); cfg_compress_en = 1'b1;
        send_beat(mk(32'hC000_0001), c_KL, 1'b1, 1'b1, {c_KL, 4'b1101});
        s_tvalid = 1'b0;
        #1;
        check("single_s_tready", s_tready, 1);
        drain(1, "single");
        if (q_last.size() == 1) check("single_last", q_last[0], 1);
        check("single_busy", busy, 0);

        // Egress stall with a single-beat tlast packet waiting at ingress.
        clear_q(); cfg_compress_en = 1'b0;
        send_beat(mk(32'hD000_0001), c_KF, 1'b0, 1'b0, '0);
        send_beat(mk(32'hD000_0002), c_KF, 1'b0, 1'b0, '0);
        send_beat(mk(32'hD000_0003), c_KF, 1'b0, 1'b0, '0);
        send_beat(mk(32'hD000_0004), c_KF, 1'b1, 1'b0, '0);
        s_tvalid = 1'b0;
        for (int k = 0; k < 20 && !m_tvalid; k++) step();
        check("stall_m_tvalid", m_tvalid, 1);
        m_tready = 1'b0;
        s_tvalid = 1'b1; s_tdata = mk(32'hD000_00FF); s_tkeep = c_KL; s_tlast = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("stall_wrten", pipe_wrtEn, 0);
            check("stall_s_tready", s_tready, 0);
            check("stall_m_tdata", m_tdata, mk(32'hD000_0001));
            step();
        end
        check("stall_m_ttag", m_ttag, 16'h0001);
        check("stall_m_tlen", m_tlen, 8'h01);
        m_tready = 1'b1;
        #1;
        check("release_s_tready", s_tready, 1);
        step();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        drain(5, "stall");
        for (int i = 0; i < 5 && i < q_data.size(); i++) begin
            check("stall_data", q_data[i], i == 4 ? mk(32'hD000_00FF) : mk(32'hD000_0001 + i));
            check("stall_last", q_last[i], i >= 3);
        end

        // Back-to-back compressed 2-beat packets, ingress valid held high.
        clear_q(); cfg_compress_en = 1'b1; waits = 0;
        send_beat(mk(32'hE000_0001), c_KF, 1'b0, 1'b0, '0);
        send_beat(mk(32'hE000_0002), c_KF, 1'b1, 1'b0, '0);
        send_beat(mk(32'hE000_0003), c_KF, 1'b0, 1'b0, '0);
        send_beat(mk(32'hE000_0004), c_KF, 1'b1, 1'b0, '0);
        s_tvalid = 1'b0;
        check("b2b_gap", waits, 1);
        drain(6, "b2b");
        for (int i = 0; i < 6 && i < q_data.size(); i++) begin
            check("b2b_last", q_last[i], i == 2 || i == 5);
            check("b2b_data", q_data[i], (i == 2 || i == 5) ? 256'h0 :
                  mk(32'hE000_0001 + (i > 2 ? i - 1 : i)));
        end

        // Reset while in PAYLOAD, then a fresh packet.
        clear_q(); cfg_compress_en = 1'b1;
        send_beat(mk(32'hF000_0001), c_KF, 1'b0, 1'b0, '0);
        send_beat(mk(32'hF000_0002), c_KF, 1'b0, 1'b0, '0);
        s_tvalid = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("midrst_busy", busy, 0);
        check("midrst_m_tvalid", m_tvalid, 0);
        reset = 1'b0;
        clear_q();
        #1;
        check("midrst_s_tready", s_tready, 1);
        send_beat(mk(32'h9000_0001), c_KF, 1'b0, 1'b1, {c_KF, 4'b1001});
        send_beat(mk(32'h9000_0002), c_KL, 1'b1, 1'b1, {c_KL, 4'b1010});
        s_tvalid = 1'b0;
        drain(3, "postrst");
        if (q_data.size() == 3) begin
            check("postrst_first", q_data[0], mk(32'h9000_0001));
            check("postrst_last", q_last[2], 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/compress_stream_ctrl.md
# compress_stream_ctrl

Stream-side sequencer for the eight-lane compress pipeline.
- Accepts 256-bit AXI-Stream beats and builds the per-beat flag word: header marking, per-packet compression enable, tlast and tkeep.
- Inserts a flush beat after compressed packets so the carried half-lane residue leaves the pipeline.
- Drives the pipeline's global write enable from downstream backpressure and presents pipeline results as an AXI-Stream master.
- Sits between the ingress packet parser and the compressed-beat packer.

## Interface
Parameters:
- LANE_WIDTH, 32, bits per compress lane
- LANES, 8, lanes per beat (beat width LANE_WIDTH*LANES)
- TAG_WIDTH, 2, tag bits per lane
- LEN_WIDTH, 8, compressed-length field width
- TKEEP_WIDTH, 32, tkeep bits per beat
- HDR_BEATS, 1, leading beats per packet forwarded uncompressed as header (≥1)
- PIPE_DEPTH, 5, enabled cycles from pipeline input to flags_out

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- cfg_compress_en  in  1  compression request, sampled on each packet's first beat
- s_tdata / s_tkeep / s_tlast / s_tvalid  in  256/32/1/1  ingress stream
- s_tready  out  1  ingress accept
- pipe_wrtEn  out  1  global pipeline enable
- pipe_dataIn  out  256  pipeline data
- pipe_flags_in  out  36  {tkeep[35:4], valid[3], tlast[2], compression[1], is_header[0]}
- pipe_dataOut / pipe_tagOut / pipe_lenOut / pipe_flags_out  in  256/16/8/36  pipeline results
- m_tdata / m_ttag / m_tlen / m_tkeep / m_tlast / m_tvalid  out  256/16/8/32/1/1  egress stream
- m_tready  in  1  egress accept
- busy  out  1  packet open or beats in flight

## Operation
- pipe_wrtEn = !(pipe_flags_out[3] && !m_tready). The whole pipeline freezes while its output beat is not taken.
- m_t* come straight from pipe_* outputs; m_tvalid = pipe_flags_out[3]; m_tkeep and m_tlast come from pipe_flags_out.
- s_tready = pipe_wrtEn && state != FLUSH.
- A beat is accepted when s_tvalid && s_tready. Accepted beats are injected with valid=1.
- Any other enabled cycle injects a bubble: data 0, flags 0.
- FSM states:
  - IDLE: first accepted beat latches pkt_comp = cfg_compress_en and sets is_header=1 and hdr_cnt=1. Next state is HDR if HDR_BEATS>1, else PAYLOAD. A tlast on this beat returns to IDLE.
  - HDR: each accepted beat has is_header=1 and increments hdr_cnt. After hdr_cnt reaches HDR_BEATS, go to PAYLOAD. A tlast returns to IDLE.
  - PAYLOAD: each beat carries compression=pkt_comp and is_header=0.
    - tlast with pkt_comp=0: pass tlast through, go to IDLE.
    - tlast with pkt_comp=1: inject the beat with tlast cleared, go to FLUSH.
  - FLUSH: on the next enabled cycle, inject data 0, tkeep 0, valid 1, tlast 1, compression 1, is_header 0, then go to IDLE. No ingress is accepted in FLUSH.
- Header beats and tlast-in-header packets never produce a flush beat.
- inflight counter (width clog2(PIPE_DEPTH+2)):
  - +1 per valid injection, −1 per egress handshake; both on the same cycle leaves it unchanged.
  - Never exceeds PIPE_DEPTH+1.
- busy = (state != IDLE) || (inflight != 0).

## Timing
- Reset (synchronous) values: state IDLE, hdr_cnt 0, pkt_comp 0, inflight 0, busy 0, pipe_flags_in 0, pipe_dataIn 0.
- With pipeline registers also reset: m_tvalid 0, hence pipe_wrtEn 1 and s_tready 1 on the first cycle after reset.
- Controller outputs to the pipeline are combinational from registered state and ingress; there is no added latency.
- Ingress-to-egress latency is exactly PIPE_DEPTH enabled cycles. Stalled cycles add one each.
- A compressed packet of N payload beats produces N+1 egress payload beats.
- A stall mid-FLUSH holds FLUSH; the flush beat is injected on the first enabled cycle.
- A simultaneous ingress tlast and egress stall means nothing is accepted (s_tready=0); the FSM does not advance.
- Reset mid-packet discards the open packet. Pipeline contents are cleared by the shared reset.

## Configuration
- COMPRESS_CTRL_STATS_EN defined adds outputs stat_pkts[31:0] and stat_flush[31:0]:
  - stat_pkts increments on each egress tlast handshake.
  - stat_flush increments on each injected flush beat.
  - Both wrap at 2^32 and reset to 0.
- Macro undefined: the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- HDR_BEATS=1, cfg_compress_en=1, 4-beat packet, m_tready=1 → 5 egress beats at cycles 5–9 after first accept. Beat 1 is_header passes uncompressed; tlast only on beat 5; busy falls the cycle after beat 5.
- Same packet with cfg_compress_en=0 → 4 egress beats, tlast on beat 4, no flush.
- Single-beat packet (tlast on header), compress on → exactly 1 egress beat with tlast, FSM back to IDLE.
- m_tready low for 10 cycles while m_tvalid=1 → pipe_wrtEn=0 and s_tready=0 throughout; m_t* held stable; no beat lost or duplicated.
- Back-to-back compressed 2-beat packets with s_tvalid continuously high → one-cycle s_tready gap at each FLUSH; 6 egress beats; inflight never exceeds 6.
- reset asserted in PAYLOAD → next cycle state IDLE, busy 0, m_tvalid 0; a following packet processes normally.
